// File: rtl/xcrypto_pkg.sv
// Shared xcrypto definitions: sequencer state encoding, word geometry, GF(2^8) helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package xcrypto_pkg;

    localparam int WORD_BYTES = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } aes_state_t;

    // Multiply in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] aa;
        acc = 8'h00;
        aa  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return acc;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0, as the S-box requires).
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] r;
        p = x;
        r = 8'h01;
        for (int i = 0; i < 7; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x} << n;
        return d[15:8];
    endfunction

    // Forward S-box affine step.
    function automatic logic [7:0] aff_fwd(input logic [7:0] b);
        return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    endfunction

    // Inverse of the affine step, applied before inversion on the decrypt path.
    function automatic logic [7:0] aff_inv(input logic [7:0] s);
        return rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05;
    endfunction

endpackage

// File: rtl/xc_aessub_sbox.sv
// One-byte AES S-box, forward or inverse selected by inv; a single shared GF inverter.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows input.
module xc_aessub_sbox
    import xcrypto_pkg::*;
(
    input  logic [7:0] din,
    input  logic       inv,
    output logic [7:0] dout
);

    logic [7:0] pre;
    logic [7:0] mid;

    // Inverse path undoes the affine map first; forward path applies it after inversion.
    always_comb begin
        pre  = inv ? aff_inv(din) : din;
        mid  = gf_inv(pre);
        dout = inv ? mid : aff_fwd(mid);
    end

endmodule

// File: rtl/xc_aessub_seq.sv
// Sequential 32-bit AES SubBytes/InvSubBytes using BYTES_PER_CYCLE S-box lanes.
// Latency: 4/BYTES_PER_CYCLE+1 cycles from accept to rsp_valid; one request in flight.
// Backpressure: req_ready only in IDLE; result held in DONE until rsp_ready.
module xc_aessub_seq
    import xcrypto_pkg::*;
#(
    parameter int BYTES_PER_CYCLE = 1
) (
    input  logic        g_clk,
    input  logic        g_resetn,
    input  logic        flush,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_data,
    input  logic        req_inv,
    input  logic        req_rot,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        busy
);

    localparam int NGROUPS = WORD_BYTES / BYTES_PER_CYCLE;
    localparam int CW      = (NGROUPS > 1) ? $clog2(NGROUPS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(NGROUPS - 1);

    if (BYTES_PER_CYCLE != 1 && BYTES_PER_CYCLE != 2 && BYTES_PER_CYCLE != 4) begin : g_bad_param
        $error("xc_aessub_seq: BYTES_PER_CYCLE must be 1, 2 or 4");
    end

    aes_state_t                         state_q;
    aes_state_t                         state_d;
    logic [CW-1:0]                      cnt_q;
    logic [WORD_BYTES-1:0][7:0]         data_q;
    logic [WORD_BYTES-1:0][7:0]         res_q;
    logic                               inv_q;
    logic                               rot_q;
    logic [BYTES_PER_CYCLE-1:0][7:0]    lane_out;
    logic                               accept;
    logic                               last_grp;

    assign accept   = req_valid && req_ready;
    assign last_grp = (cnt_q == CNT_LAST);
    assign busy     = (state_q != ST_IDLE);

    // One lane per byte handled per cycle, fed straight from the captured word.
    for (genvar l = 0; l < BYTES_PER_CYCLE; l++) begin : g_lane
        xc_aessub_sbox u_sbox (
            .din  (data_q[2'(int'(cnt_q) * BYTES_PER_CYCLE + l)]),
            .inv  (inv_q),
            .dout (lane_out[l])
        );
    end

    // State register.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) state_q <= ST_IDLE;
        else           state_q <= state_d;
    end

    // Next-state and handshake outputs; flush wins over any same-cycle handshake.
    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready = !flush;
                if (req_valid && !flush) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (last_grp) state_d = ST_DONE;
            end
            ST_DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (flush) state_d = ST_IDLE;
    end

    // Capture on accept, then fill the result register one group per RUN cycle.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            cnt_q  <= '0;
            data_q <= '0;
            res_q  <= '0;
            inv_q  <= 1'b0;
            rot_q  <= 1'b0;
        end else if (flush) begin
            cnt_q  <= '0;
            data_q <= '0;
            res_q  <= '0;
            inv_q  <= 1'b0;
            rot_q  <= 1'b0;
        end else if (accept) begin
            cnt_q  <= '0;
            data_q <= req_data;
            res_q  <= '0;
            inv_q  <= req_inv;
            rot_q  <= req_rot;
        end else if (state_q == ST_RUN) begin
            cnt_q <= last_grp ? '0 : cnt_q + CW'(1);
            for (int l = 0; l < BYTES_PER_CYCLE; l++) begin
                res_q[2'(int'(cnt_q) * BYTES_PER_CYCLE + l)] <= lane_out[l];
            end
        end
    end

    // Result is only exposed once every byte has been substituted.
    always_comb begin
        rsp_data = '0;
        if (state_q == ST_DONE) begin
            rsp_data = rot_q ? {res_q[2:0], res_q[3]} : res_q;
        end
    end

endmodule

// File: tb/tb_xc_aessub_seq.sv
// Self-checking bench: one DUT per lane count (1, 2, 4), directed vectors plus random traffic.
// Reference: S-box tables generated by the generator-walk construction, inverse by table inversion.
// Responses are compared for value, latency, hold stability, flush and reset behaviour.
module tb_xc_aessub_seq;

    localparam int ND = 3;

    logic        g_clk = 1'b0;
    logic        g_resetn;
    logic        flush     [ND];
    logic        req_valid [ND];
    logic        req_ready [ND];
    logic [31:0] req_data  [ND];
    logic        req_inv   [ND];
    logic        req_rot   [ND];
    logic        rsp_valid [ND];
    logic        rsp_ready [ND];
    logic [31:0] rsp_data  [ND];
    logic        busy      [ND];

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] fwd_tab [256];
    logic [7:0] inv_tab [256];

    always #5 g_clk = ~g_clk;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        xc_aessub_seq #(.BYTES_PER_CYCLE(1 << g)) u_dut (
            .g_clk     (g_clk),
            .g_resetn  (g_resetn),
            .flush     (flush[g]),
            .req_valid (req_valid[g]),
            .req_ready (req_ready[g]),
            .req_data  (req_data[g]),
            .req_inv   (req_inv[g]),
            .req_rot   (req_rot[g]),
            .rsp_valid (rsp_valid[g]),
            .rsp_ready (rsp_ready[g]),
            .rsp_data  (rsp_data[g]),
            .busy      (busy[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] rl(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x} << n;
        return d[15:8];
    endfunction

    // Walk p over all nonzero elements via generator 3 while q tracks 1/p.
    task automatic build_tables();
        logic [7:0] p;
        logic [7:0] q;
        logic [7:0] x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'b0000};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rl(q, 1) ^ rl(q, 2) ^ rl(q, 3) ^ rl(q, 4);
            fwd_tab[p] = x ^ 8'h63;
        end while (p != 8'h01);
        fwd_tab[0] = 8'h63;
        for (int i = 0; i < 256; i++) inv_tab[fwd_tab[i]] = 8'(i);
    endtask

    function automatic logic [31:0] model(input logic [31:0] w, input logic inv, input logic rot);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) begin
            r[8*b +: 8] = inv ? inv_tab[w[8*b +: 8]] : fwd_tab[w[8*b +: 8]];
        end
        return rot ? {r[23:0], r[31:24]} : r;
    endfunction

    task automatic tick();
        @(posedge g_clk);
        #1;
    endtask

    // One request through DUT d; rsp_ready held low for 'hold' DONE cycles.
    task automatic run_txn(input int d, input logic [31:0] data, input logic inv,
                           input logic rot, input int hold, input logic poke);
        int          w;
        int          lat;
        logic [31:0] exp;
        logic [31:0] first;
        string       t;
        t   = $sformatf("d%0d", d);
        exp = model(data, inv, rot);
        w   = 0;
        while (!req_ready[d] && w < 20) begin
            tick();
            w++;
        end
        if (!req_ready[d]) begin
            check({t, "_ready_timeout"}, 32'(req_ready[d]), 32'd1);
            return;
        end
        rsp_ready[d] = (hold == 0);
        req_valid[d] = 1'b1;
        req_data[d]  = data;
        req_inv[d]   = inv;
        req_rot[d]   = rot;
        tick();
        lat = 1;
        req_valid[d] = poke;
        req_data[d]  = $urandom;
        req_inv[d]   = 1'($urandom);
        req_rot[d]   = 1'($urandom);
        while (!rsp_valid[d] && lat < 20) begin
            tick();
            lat++;
        end
        check({t, "_latency"}, 32'(lat), 32'(4 / (1 << d) + 1));
        check({t, "_rsp_data"}, rsp_data[d], exp);
        first = rsp_data[d];
        for (int i = 0; i < hold; i++) begin
            tick();
            check({t, "_hold_valid"}, 32'(rsp_valid[d]), 32'd1);
            check({t, "_hold_data"}, rsp_data[d], first);
            check({t, "_hold_req_ready"}, 32'(req_ready[d]), 32'd0);
        end
        rsp_ready[d] = 1'b1;
        tick();
        req_valid[d] = 1'b0;
        check({t, "_post_busy"}, 32'(busy[d]), 32'd0);
        check({t, "_post_valid"}, 32'(rsp_valid[d]), 32'd0);
        check({t, "_post_req_ready"}, 32'(req_ready[d]), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion before it");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        build_tables();
        g_resetn = 1'b0;
        for (int d = 0; d < ND; d++) begin
            flush[d]     = 1'b0;
            req_valid[d] = 1'b0;
            req_data[d]  = '0;
            req_inv[d]   = 1'b0;
            req_rot[d]   = 1'b0;
            rsp_ready[d] = 1'b1;
        end
        #2;
        for (int d = 0; d < ND; d++) begin
            check($sformatf("d%0d_rst_req_ready", d), 32'(req_ready[d]), 32'd1);
            check($sformatf("d%0d_rst_rsp_valid", d), 32'(rsp_valid[d]), 32'd0);
            check($sformatf("d%0d_rst_busy", d), 32'(busy[d]), 32'd0);
            check($sformatf("d%0d_rst_rsp_data", d), rsp_data[d], 32'd0);
        end
        tick();
        tick();
        g_resetn = 1'b1;
        tick();
        check("d0_after_rst_req_ready", 32'(req_ready[0]), 32'd1);
        check("d0_after_rst_busy", 32'(busy[0]), 32'd0);

        // Directed vectors.
        run_txn(0, 32'h53020100, 1'b0, 1'b0, 0, 1'b0);
        check("model_fwd_vec", model(32'h53020100, 1'b0, 1'b0), 32'hED777C63);
        run_txn(0, 32'hED777C63, 1'b1, 1'b0, 0, 1'b0);
        run_txn(2, 32'hED777C63, 1'b1, 1'b0, 0, 1'b0);
        run_txn(1, 32'hED777C63, 1'b1, 1'b0, 0, 1'b0);
        run_txn(0, 32'h53020100, 1'b0, 1'b1, 0, 1'b0);
        run_txn(0, 32'h53020100, 1'b0, 1'b0, 10, 1'b1);

        // Flush in the second RUN cycle discards the operation.
        req_valid[0] = 1'b1;
        req_data[0]  = 32'h12345678;
        req_inv[0]   = 1'b0;
        req_rot[0]   = 1'b0;
        tick();
        req_valid[0] = 1'b0;
        tick();
        flush[0] = 1'b1;
        tick();
        flush[0] = 1'b0;
        check("flush_busy", 32'(busy[0]), 32'd0);
        check("flush_rsp_valid", 32'(rsp_valid[0]), 32'd0);
        // Flush in IDLE blocks a same-cycle request.
        flush[0]     = 1'b1;
        req_valid[0] = 1'b1;
        #1;
        check("flush_req_ready", 32'(req_ready[0]), 32'd0);
        tick();
        req_valid[0] = 1'b0;
        flush[0]     = 1'b0;
        check("flush_no_accept", 32'(busy[0]), 32'd0);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (rsp_valid[0]) seen++;
        end
        check("flush_no_rsp", 32'(seen), 32'd0);
        run_txn(0, 32'h00000000, 1'b0, 1'b0, 0, 1'b0);

        // Asynchronous reset in the middle of RUN.
        req_valid[0] = 1'b1;
        req_data[0]  = 32'hA5A5A5A5;
        tick();
        req_valid[0] = 1'b0;
        tick();
        #3;
        g_resetn = 1'b0;
        #1;
        check("arst_busy", 32'(busy[0]), 32'd0);
        check("arst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
        check("arst_rsp_data", rsp_data[0], 32'd0);
        check("arst_req_ready", 32'(req_ready[0]), 32'd1);
        tick();
        g_resetn = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (rsp_valid[0] || busy[0]) seen++;
        end
        check("arst_no_rsp", 32'(seen), 32'd0);

        // Random traffic on every lane configuration.
        for (int d = 0; d < ND; d++) begin
            for (int k = 0; k < 15; k++) begin
                run_txn(d, $urandom, 1'($urandom), 1'($urandom),
                        int'($urandom_range(0, 3)), 1'($urandom));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/xc_aessub_seq.md
XC_AESSUB_SEQ -- requirements
Module: xc_aessub_seq

Interface
REQ-001 SHALL have parameter BYTES_PER_CYCLE, default 1; number of S-box lanes instantiated; legal values 1, 2, 4.
REQ-002 SHALL have port g_clk, input, 1 bit; single clock, rising edge.
REQ-003 SHALL have port g_resetn, input, 1 bit; reset, asynchronous assertion, active-low.
REQ-004 SHALL have port flush, input, 1 bit; synchronous abort of any operation in progress.
REQ-005 SHALL have port req_valid, input, 1 bit; request word is valid.
REQ-006 SHALL have port req_ready, output, 1 bit; block accepts a request this cycle.
REQ-007 SHALL have port req_data, input, 32 bits; four bytes to substitute.
REQ-008 SHALL have port req_inv, input, 1 bit; 1 = inverse S-box, 0 = forward S-box.
REQ-009 SHALL have port req_rot, input, 1 bit; 1 = rotate result left by 8 bits.
REQ-010 SHALL have port rsp_valid, output, 1 bit; result is valid.
REQ-011 SHALL have port rsp_ready, input, 1 bit; consumer takes the result.
REQ-012 SHALL have port rsp_data, output, 32 bits; substituted word.
REQ-013 SHALL have port busy, output, 1 bit; high in any state other than IDLE.

Function
REQ-014 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-015 SHALL drive req_ready=1 only in IDLE, and only when flush=0.
REQ-016 SHALL, on req_valid&&req_ready, capture req_data, req_inv and req_rot, clear the lane counter, and enter RUN.
REQ-017 SHALL ignore changes on req_* after acceptance.
REQ-018 SHALL, in each RUN cycle, substitute BYTES_PER_CYCLE bytes starting at byte index cnt*BYTES_PER_CYCLE (byte 0 = bits 7:0 first) and write each result into the same byte position of the result register.
REQ-019 SHALL advance the lane counter by 1 per RUN cycle; the counter is log2(4/BYTES_PER_CYCLE) bits wide, minimum 1.
REQ-020 SHALL move RUN->DONE on the cycle the final group is written, so RUN lasts exactly 4/BYTES_PER_CYCLE cycles.
REQ-021 SHALL drive rsp_valid=1 in DONE only, with rsp_data stable for as long as rsp_valid is held.
REQ-022 SHALL drive rsp_data as the result register when rot=0, or {res[23:0],res[31:24]} when rot=1; bytes not yet substituted SHALL never be visible.
REQ-023 SHALL move DONE->IDLE on rsp_valid&&rsp_ready; DONE SHALL hold indefinitely while rsp_ready=0.
REQ-024 SHALL make acceptance-to-rsp_valid latency 4/BYTES_PER_CYCLE+1 cycles (5, 3 or 2), with one request in flight at most.
REQ-025 SHALL NOT accept a new request in the same cycle as the response handshake; the earliest next acceptance is the following cycle.
REQ-026 SHALL force the FSM to IDLE on the next edge when flush=1 in any state, discarding captured data; flush overrides a same-cycle request (req_ready=0) and a same-cycle response handshake.
REQ-027 SHALL use the S-box lane combinationally from the captured byte, with no registers inside the lane.

Reset
REQ-028 SHALL, while g_resetn=0, hold the FSM in IDLE, the lane counter at 0, the result and captured registers at 0, and the inv/rot flags at 0.
REQ-029 SHALL output req_ready=1, rsp_valid=0, busy=0 and rsp_data=0 during and immediately after reset.
REQ-030 SHALL, when reset is asserted mid-RUN or in DONE, abandon the operation with no response produced.

Structure
REQ-031 SHALL place the FSM state encoding (2 bits: IDLE=0, RUN=1, DONE=2) and the constant WORD_BYTES=4 in the shared xcrypto package.
REQ-032 SHALL instantiate the existing one-byte forward/inverse S-box module (xc_aessub_sbox) once per lane via a generate loop; no other sub-modules.

Verification
REQ-033 SHALL cover, with BYTES_PER_CYCLE=1: req_data=0x53020100, inv=0, rot=0 -> rsp_data=0xED777C63 with rsp_valid asserted 5 cycles after acceptance.
REQ-034 SHALL cover: req_data=0xED777C63, inv=1, rot=0 -> rsp_data=0x53020100; the same test with BYTES_PER_CYCLE=4 -> latency 2 cycles.
REQ-035 SHALL cover: req_data=0x53020100, inv=0, rot=1 -> rsp_data=0x777C63ED.
REQ-036 SHALL cover: rsp_ready held at 0 for 10 cycles in DONE -> rsp_valid and rsp_data stay stable, req_ready stays 0, with no second accept; after the handshake, req_ready=1 on the following cycle.
REQ-037 SHALL cover: flush pulsed during the 2nd RUN cycle -> IDLE next cycle with no rsp_valid; a following request 0x00000000 with inv=0 -> 0x63636363.
REQ-038 SHALL cover: g_resetn asserted asynchronously mid-RUN -> busy=0, rsp_valid=0 and rsp_data=0 immediately, with no response after release.
